coin_bank_ctrl: RTL and testbench
=================================

// Module: coin_bank_ctrl
// PURPOSE
//  Parametrised successor to the 4-coin digital counter. Tallies inserted coins of NUM_TYPES
//  denominations, keeps a running total, and adds a change-payout engine. The engine
//  dispenses coins greedily, one per clock, and decrements the tallies as it goes.
//  Sits between the coin acceptor front-end and the dispenser/vending controller.
// PARAMETERS
//  NUM_TYPES    4                       number of coin denominations
//  TYPE_W       2                       coin_type width; $clog2(NUM_TYPES), minimum 1
//  COUNT_W      8                       per-denomination tally width
//  TOTAL_W      16                      total_value / payout_amount width
//  VAL_W        8                       width of one denomination value
//  COIN_VALUES  {8'd10,8'd5,8'd2,8'd1}  packed values; type i = [i*VAL_W +: VAL_W]
//                                       must be strictly ascending with i and non-zero
// PORTS
//  clk            in   1                  rising-edge clock
//  reset_n        in   1                  asynchronous, active-low reset
//  coin_insert    in   1                  level; each 0->1 transition is one coin
//  coin_type      in   TYPE_W             denomination index; sampled with the insert edge
//  coin_accept    out  1                  1-cycle pulse: coin counted
//  coin_reject    out  1                  1-cycle pulse: coin refused, no state change
//  payout_req     in   1                  request change; honoured only when payout_busy=0
//  payout_amount  in   TOTAL_W            amount to pay out; sampled with payout_req
//  payout_busy    out  1                  high while the FSM is not in IDLE
//  dispense_valid out  1                  1-cycle pulse per dispensed coin
//  dispense_type  out  TYPE_W             denomination of the dispensed coin; 0 when not valid
//  payout_done    out  1                  1-cycle pulse: payout completed exactly
//  payout_fail    out  1                  1-cycle pulse: payout aborted
//  total_value    out  TOTAL_W            sum of count[i]*value[i]
//  coin_counts    out  NUM_TYPES*COUNT_W  tally of type i at [i*COUNT_W +: COUNT_W]
// BEHAVIOUR
//  Reset: all outputs, tallies, total, insert-edge register and remaining register
//   are cleared to 0; state = IDLE. The reset is asynchronous and can abort any payout;
//   no done/fail pulse is emitted.
//  Insert edge: coin_insert=1 while the registered prior sample is 0.
//   On that clk edge, accept if all hold: state is IDLE, count[type] < 2^COUNT_W-1,
//   and total+value < 2^TOTAL_W.
//   Accept: count[type]+1, total+value, coin_accept=1 from the same edge.
//   Otherwise: coin_reject=1 and nothing else changes (no saturation/wrap).
//   A held-high coin_insert counts once only.
//  FSM states: IDLE, PAYOUT, DONE, FAIL.
//   IDLE: on payout_req with amount > total_value -> FAIL.
//    On payout_req with amount==0 -> DONE.
//    On any other payout_req: latch remaining=amount -> PAYOUT.
//    If an insert edge and payout_req occur in the same cycle, the payout wins and the
//    coin is rejected.
//   PAYOUT, each cycle: pick the highest i with count[i]>0 and value[i]<=remaining.
//    If found: dispense_valid=1, dispense_type=i, count[i]-1, total-value[i],
//    remaining-value[i]. If remaining becomes 0 -> DONE, else stay in PAYOUT.
//    If none found -> FAIL. Coins already dispensed are not restored.
//   DONE: payout_done=1 for one cycle -> IDLE.  FAIL: payout_fail=1 for one cycle -> IDLE.
//   payout_req outside IDLE is ignored. Insert edges outside IDLE are rejected.
//  Latency: first coin appears 1 cycle after the req edge; one coin per cycle after that.
//   done/fail follows the last dispense by 1 cycle.
//  Greedy selection can fail where an exact non-greedy solution exists; this is accepted.
// STRUCTURE
//  Shared package coin_bank_pkg: FSM state encoding, default COIN_VALUES, VAL_W.
//  Sub-module coin_greedy_select (combinational): inputs = counts, values, remaining;
//   outputs = found, idx. It is a priority search from the highest index down.
//  Top level: edge detector, tally/total registers, remaining register, FSM.
// TESTING
//  1. Reset, then insert types 0,1,2,3 in turn -> accept x4; counts 1,1,1,1; total=18.
//  2. Hold coin_insert high 5 cycles with type 2 -> exactly one accept; total +5.
//  3. After test 1, payout 17 -> dispense types 3,2,1 on consecutive cycles, then done;
//     total=1; counts 1,0,0,0.
//  4. Counts 0,0,2,0 (total 10), payout 3 -> no dispense, fail next cycle.
//     Payout 12 -> fail (amount > total). Both leave tallies unchanged.
//  5. count[0]=255 then insert type 0 -> reject; count and total unchanged.
//     Insert during PAYOUT -> reject.
//  6. Drop reset_n mid-payout -> all outputs 0 immediately, no done/fail; IDLE on release.

Source files
------------

// File: rtl/coin_bank_pkg.sv
// Shared types and defaults for the coin bank controller.
// Payout FSM encoding and the default denomination table.
package coin_bank_pkg;

    localparam int DEF_VAL_W = 8;
    localparam logic [4*DEF_VAL_W-1:0] DEF_COIN_VALUES =
        {8'd10, 8'd5, 8'd2, 8'd1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYOUT,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/coin_greedy_select.sv
// Greedy change picker: the largest denomination that is in stock
// and still fits into the remaining amount.
module coin_greedy_select
    import coin_bank_pkg::*;
#(
    parameter int NUM_TYPES = 4,
    parameter int TYPE_W    = 2,
    parameter int COUNT_W   = 8,
    parameter int VAL_W     = DEF_VAL_W,
    parameter int TOTAL_W   = 16
) (
    input  logic [NUM_TYPES*COUNT_W-1:0] counts,
    input  logic [NUM_TYPES*VAL_W-1:0]   values,
    input  logic [TOTAL_W-1:0]           remaining,
    output logic                         found,
    output logic [TYPE_W-1:0]            idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_TYPES - 1; i >= 0; i--) begin
            if (!found &&
                counts[i*COUNT_W +: COUNT_W] != '0 &&
                TOTAL_W'(values[i*VAL_W +: VAL_W]) <= remaining) begin
                found = 1'b1;
                idx   = TYPE_W'(i);
            end
        end
    end

endmodule

// File: rtl/coin_bank_ctrl.sv
// Coin tally with running total and a one-coin-per-clock greedy
// change payout engine.
module coin_bank_ctrl
    import coin_bank_pkg::*;
#(
    parameter int NUM_TYPES = 4,
    parameter int TYPE_W    = 2,
    parameter int COUNT_W   = 8,
    parameter int TOTAL_W   = 16,
    parameter int VAL_W     = DEF_VAL_W,
    parameter logic [NUM_TYPES*VAL_W-1:0] COIN_VALUES = DEF_COIN_VALUES
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         coin_insert,
    input  logic [TYPE_W-1:0]            coin_type,
    output logic                         coin_accept,
    output logic                         coin_reject,
    input  logic                         payout_req,
    input  logic [TOTAL_W-1:0]           payout_amount,
    output logic                         payout_busy,
    output logic                         dispense_valid,
    output logic [TYPE_W-1:0]            dispense_type,
    output logic                         payout_done,
    output logic                         payout_fail,
    output logic [TOTAL_W-1:0]           total_value,
    output logic [NUM_TYPES*COUNT_W-1:0] coin_counts
);

    state_t                       state_q;
    logic                         ins_q;
    logic [TOTAL_W-1:0]           rem_q;
    logic [NUM_TYPES*COUNT_W-1:0] counts_q;
    logic [TOTAL_W-1:0]           total_q;

    logic                         ins_edge;
    logic                         in_range;
    logic [COUNT_W-1:0]           cnt_sel;
    logic [TOTAL_W:0]             sum_ins;
    logic                         can_accept;
    logic                         found;
    logic [TYPE_W-1:0]            pick;
    logic [TOTAL_W-1:0]           pick_val;

    assign ins_edge = coin_insert & ~ins_q;
    assign in_range = int'(coin_type) < NUM_TYPES;
    assign cnt_sel  = counts_q[coin_type*COUNT_W +: COUNT_W];
    assign sum_ins  = {1'b0, total_q} +
        (TOTAL_W+1)'(COIN_VALUES[coin_type*VAL_W +: VAL_W]);

    // A payout request in the same cycle takes priority over a coin.
    assign can_accept = (state_q == ST_IDLE) && !payout_req &&
                        in_range && (cnt_sel != '1) && !sum_ins[TOTAL_W];

    coin_greedy_select #(
        .NUM_TYPES (NUM_TYPES),
        .TYPE_W    (TYPE_W),
        .COUNT_W   (COUNT_W),
        .VAL_W     (VAL_W),
        .TOTAL_W   (TOTAL_W)
    ) u_select (
        .counts    (counts_q),
        .values    (COIN_VALUES),
        .remaining (rem_q),
        .found     (found),
        .idx       (pick)
    );

    assign pick_val    = TOTAL_W'(COIN_VALUES[pick*VAL_W +: VAL_W]);
    assign payout_busy = (state_q != ST_IDLE);
    assign total_value = total_q;
    assign coin_counts = counts_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ins_q          <= 1'b0;
            rem_q          <= '0;
            counts_q       <= '0;
            total_q        <= '0;
            coin_accept    <= 1'b0;
            coin_reject    <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_type  <= '0;
            payout_done    <= 1'b0;
            payout_fail    <= 1'b0;
        end else begin
            ins_q          <= coin_insert;
            coin_accept    <= 1'b0;
            coin_reject    <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_type  <= '0;
            payout_done    <= 1'b0;
            payout_fail    <= 1'b0;

            if (ins_edge) begin
                if (can_accept) begin
                    counts_q[coin_type*COUNT_W +: COUNT_W] <= cnt_sel + 1'b1;
                    total_q     <= sum_ins[TOTAL_W-1:0];
                    coin_accept <= 1'b1;
                end else begin
                    coin_reject <= 1'b1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (payout_req) begin
                        if (payout_amount > total_q) begin
                            state_q <= ST_FAIL;
                        end else if (payout_amount == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            rem_q   <= payout_amount;
                            state_q <= ST_PAYOUT;
                        end
                    end
                end
                ST_PAYOUT: begin
                    if (found) begin
                        dispense_valid <= 1'b1;
                        dispense_type  <= pick;
                        counts_q[pick*COUNT_W +: COUNT_W] <=
                            counts_q[pick*COUNT_W +: COUNT_W] - 1'b1;
                        total_q <= total_q - pick_val;
                        rem_q   <= rem_q - pick_val;
                        if (rem_q == pick_val) state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_FAIL;
                    end
                end
                ST_DONE: begin
                    payout_done <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_FAIL: begin
                    payout_fail <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_bank_ctrl.sv
// Scoreboard bench for coin_bank_ctrl: expected pulses are queued
// with their due cycle and retired by a negedge monitor.
module tb_coin_bank_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        coin_insert = 1'b0;
    logic [1:0]  coin_type = '0;
    logic        payout_req = 1'b0;
    logic [15:0] payout_amount = '0;
    logic        coin_accept, coin_reject, payout_busy;
    logic        dispense_valid, payout_done, payout_fail;
    logic [1:0]  dispense_type;
    logic [15:0] total_value;
    logic [31:0] coin_counts;

    coin_bank_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .coin_insert    (coin_insert),
        .coin_type      (coin_type),
        .coin_accept    (coin_accept),
        .coin_reject    (coin_reject),
        .payout_req     (payout_req),
        .payout_amount  (payout_amount),
        .payout_busy    (payout_busy),
        .dispense_valid (dispense_valid),
        .dispense_type  (dispense_type),
        .payout_done    (payout_done),
        .payout_fail    (payout_fail),
        .total_value    (total_value),
        .coin_counts    (coin_counts)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef enum {EV_ACC, EV_REJ, EV_DISP, EV_DONE, EV_FAIL} ev_t;
    typedef struct {
        ev_t kind;
        int  typ;
        int  cyc;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0;
    int n_fail = 0;
    int m_cnt[4];
    int m_total = 0;
    int vals[4] = '{1, 2, 5, 10};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void expect_ev(ev_t k, int typ, int c);
        exp_t e;
        e.kind = k;
        e.typ  = typ;
        e.cyc  = c;
        sbq.push_back(e);
    endfunction

    task automatic take(input ev_t k, input int typ, input string tag);
        int idx[$];
        idx = sbq.find_first_index(item) with (item.kind == k);
        if (idx.size() == 0) begin
            chk({tag, "_unexpected"}, 1, 0);
        end else begin
            chk({tag, "_cycle"}, cyc, sbq[idx[0]].cyc);
            if (k == EV_DISP) chk("disp_type", typ, sbq[idx[0]].typ);
            sbq.delete(idx[0]);
        end
    endtask

    always @(negedge clk) begin
        if (coin_accept) take(EV_ACC, 0, "accept");
        if (coin_reject) take(EV_REJ, 0, "reject");
        if (dispense_valid) take(EV_DISP, int'(dispense_type), "dispense");
        else chk("dtype_idle", dispense_type, 0);
        if (payout_done) take(EV_DONE, 0, "done");
        if (payout_fail) take(EV_FAIL, 0, "fail");
    end

    // Reference greedy payout; returns cycles until the final pulse.
    function automatic int push_payout(int amt, int c);
        int rem;
        int pick;
        rem = amt;
        if (amt > m_total) begin
            expect_ev(EV_FAIL, 0, c + 2);
            return 2;
        end
        if (amt == 0) begin
            expect_ev(EV_DONE, 0, c + 2);
            return 2;
        end
        for (int k = 0; k < 600; k++) begin
            pick = -1;
            for (int i = 3; i >= 0; i--)
                if (pick < 0 && m_cnt[i] > 0 && vals[i] <= rem) pick = i;
            if (pick < 0) begin
                expect_ev(EV_FAIL, 0, c + 3 + k);
                return 3 + k;
            end
            expect_ev(EV_DISP, pick, c + 2 + k);
            m_cnt[pick]--;
            m_total -= vals[pick];
            rem -= vals[pick];
            if (rem == 0) begin
                expect_ev(EV_DONE, 0, c + 3 + k);
                return 3 + k;
            end
        end
        return 0;
    endfunction

    task automatic ins(input int t, input int hold);
        coin_type   = 2'(t);
        coin_insert = 1'b1;
        if (m_cnt[t] < 255 && m_total + vals[t] < 65536) begin
            expect_ev(EV_ACC, t, cyc + 1);
            m_cnt[t]++;
            m_total += vals[t];
        end else begin
            expect_ev(EV_REJ, t, cyc + 1);
        end
        repeat (hold) @(negedge clk);
        coin_insert = 1'b0;
        @(negedge clk);
    endtask

    task automatic pay(input int amt, input bit ins_during);
        int n;
        n = push_payout(amt, cyc);
        if (ins_during) expect_ev(EV_REJ, 0, cyc + 2);
        payout_amount = 16'(amt);
        payout_req    = 1'b1;
        @(negedge clk);
        payout_req = 1'b0;
        chk("busy_in_payout", payout_busy, 1);
        if (ins_during) coin_insert = 1'b1;
        @(negedge clk);
        coin_insert = 1'b0;
        repeat (n) @(negedge clk);
        chk("busy_after", payout_busy, 0);
    endtask

    task automatic chk_model(input string tag);
        for (int i = 0; i < 4; i++)
            chk({tag, "_cnt"}, coin_counts[i*8 +: 8], m_cnt[i]);
        chk({tag, "_total"}, total_value, m_total);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_total = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_counts", coin_counts, 0);
        chk("rst_total", total_value, 0);
        chk("rst_busy", payout_busy, 0);
        chk("rst_pulses", {coin_accept, coin_reject, dispense_valid,
                           payout_done, payout_fail}, 0);

        for (int t = 0; t < 4; t++) ins(t, 1);
        chk("t1_counts", coin_counts, 32'h0101_0101);
        chk("t1_total", total_value, 18);

        pay(17, 1'b0);
        chk("t3_counts", coin_counts, 32'h0000_0001);
        chk("t3_total", total_value, 1);
        chk_model("t3");

        ins(2, 5);
        chk("t2_total", total_value, 6);
        chk_model("t2");

        pay(0, 1'b0);
        chk_model("zero_pay");

        do_reset();
        ins(2, 1);
        ins(2, 1);
        chk("t4_counts", coin_counts, 32'h0002_0000);
        pay(3, 1'b0);
        chk("t4a_counts", coin_counts, 32'h0002_0000);
        pay(12, 1'b0);
        chk("t4b_counts", coin_counts, 32'h0002_0000);
        chk("t4b_total", total_value, 10);

        for (int i = 0; i < 255; i++) ins(0, 1);
        chk("t5_cnt0", coin_counts[7:0], 255);
        chk("t5_total", total_value, 265);
        ins(0, 1);
        chk("t5_sat_cnt0", coin_counts[7:0], 255);
        chk("t5_sat_total", total_value, 265);
        pay(15, 1'b1);
        chk_model("t5_pay");

        begin
            int n;
            n = push_payout(40, cyc);
            payout_amount = 16'd40;
            payout_req    = 1'b1;
            @(negedge clk);
            payout_req = 1'b0;
            repeat (2) @(negedge clk);
            chk("pre_rst_disp", dispense_valid, 1);
            #2 reset_n = 1'b0;
            #1;
            chk("rst_disp", dispense_valid, 0);
            chk("rst_busy_mid", payout_busy, 0);
            chk("rst_total_mid", total_value, 0);
            chk("rst_counts_mid", coin_counts, 0);
            chk("rst_done_fail", {payout_done, payout_fail}, 0);
            sbq.delete();
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_total = 0;
            @(negedge clk);
            reset_n = 1'b1;
            repeat (n + 2) @(negedge clk);
            chk("post_rst_busy", payout_busy, 0);
        end
        ins(3, 1);
        chk_model("post_rst");

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
